// File: rtl/pll_lock_ctrl_pkg.sv
// rtl/pll_lock_ctrl_pkg.sv - shared state encoding and counter sizing for the PLL lock supervisor
package pll_lock_ctrl_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    // One counter serves every state, so size it for the longest interval.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for asynchronous status inputs
module pll_lock_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - PLL bring-up, lock qualification, retry and loss-of-lock supervisor
module pll_lock_ctrl #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int DROP_FILTER         = 4,
    parameter int MAX_RETRY           = 3
) (
    input  logic       i_refclk,
    input  logic       i_rst,
    input  logic       i_pll_locked,
    input  logic       i_relock_req,
    output logic       o_pll_rst,
    output logic       o_sys_reset,
    output logic       o_ready,
    output logic       o_fail,
    output logic [1:0] o_retry_count
);
    import pll_lock_ctrl_pkg::*;

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                  LOCK_STABLE_CYCLES, DROP_FILTER);

    logic          w_locked_s;
    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [1:0]    r_retry;
    logic [1:0]    w_retry_nx;
    logic          r_pll_rst;
    logic          r_sys_reset;
    logic          r_ready;
    logic          r_fail;

    pll_lock_sync u_lock_sync (
        .i_clk   (i_refclk),
        .i_rst   (i_rst),
        .i_async (i_pll_locked),
        .o_sync  (w_locked_s)
    );

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_retry_nx = r_retry;
        if (i_relock_req) begin
            w_state_nx = PLL_RST;
            w_cnt_nx   = '0;
            w_retry_nx = 2'd0;
        end else begin
            case (r_state)
                PLL_RST: begin
                    if (r_cnt == CW'(PLL_RST_CYCLES - 1)) begin
                        w_state_nx = WAIT_LOCK;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_nx = STABLE;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        w_cnt_nx = '0;
                        if (r_retry == 2'(MAX_RETRY)) begin
                            w_state_nx = FAIL;
                        end else begin
                            w_state_nx = PLL_RST;
                            w_retry_nx = r_retry + 2'd1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                STABLE: begin
                    if (!w_locked_s) begin
                        w_state_nx = WAIT_LOCK;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
                        w_state_nx = RUN;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                RUN: begin
                    // Count only consecutive unlocked cycles so short glitches are absorbed.
                    if (w_locked_s) begin
                        w_cnt_nx = '0;
                    end else if (r_cnt == CW'(DROP_FILTER - 1)) begin
                        w_state_nx = PLL_RST;
                        w_cnt_nx   = '0;
                        w_retry_nx = 2'd0;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
                FAIL: begin
                    w_cnt_nx = '0;
                end
                default: begin
                    w_state_nx = PLL_RST;
                    w_cnt_nx   = '0;
                    w_retry_nx = 2'd0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge i_refclk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_retry     <= 2'd0;
            r_pll_rst   <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_retry     <= w_retry_nx;
            r_pll_rst   <= (w_state_nx == PLL_RST);
            r_sys_reset <= (w_state_nx != RUN);
            r_ready     <= (w_state_nx == RUN);
            r_fail      <= (w_state_nx == FAIL);
        end
    end

    assign o_pll_rst     = r_pll_rst;
    assign o_sys_reset   = r_sys_reset;
    assign o_ready       = r_ready;
    assign o_fail        = r_fail;
    assign o_retry_count = r_retry;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb/tb_pll_lock_ctrl.sv - directed table-driven bench for the PLL lock supervisor
module tb_pll_lock_ctrl;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [1:0] retry_count;

    int total;
    int bad;
    int row_idx;
    int cyc_idx;

    typedef struct {
        int         n;
        logic       rst;
        logic       lk;
        logic       rq;
        logic       pr;
        logic       sr;
        logic       rd;
        logic       fl;
        logic [1:0] rc;
    } vec_t;

    vec_t tbl[$];

    pll_lock_ctrl #(
        .PLL_RST_CYCLES      (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .DROP_FILTER         (2),
        .MAX_RETRY           (2)
    ) dut (
        .i_refclk      (refclk),
        .i_rst         (rst),
        .i_pll_locked  (pll_locked),
        .i_relock_req  (relock_req),
        .o_pll_rst     (pll_rst),
        .o_sys_reset   (sys_reset),
        .o_ready       (ready),
        .o_fail        (fail),
        .o_retry_count (retry_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d cyc=%0d got=%0h want=%0h", nm, row_idx, cyc_idx, act, exp);
        end
    endtask

    task automatic chk_all(input logic pr, input logic sr, input logic rd, input logic fl,
                           input logic [1:0] rc);
        chk("pll_rst", 32'(pll_rst), 32'(pr));
        chk("sys_reset", 32'(sys_reset), 32'(sr));
        chk("ready", 32'(ready), 32'(rd));
        chk("fail", 32'(fail), 32'(fl));
        chk("retry_count", 32'(retry_count), 32'(rc));
    endtask

    task automatic add(input int n, input logic r, input logic lk, input logic rq,
                       input logic pr, input logic sr, input logic rd, input logic fl,
                       input logic [1:0] rc);
        vec_t v;
        v.n = n; v.rst = r; v.lk = lk; v.rq = rq;
        v.pr = pr; v.sr = sr; v.rd = rd; v.fl = fl; v.rc = rc;
        tbl.push_back(v);
    endtask

    initial begin
        total = 0;
        bad = 0;
        row_idx = -1;
        cyc_idx = 0;
        rst = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // clean bring-up: locked rises before edge 11, RUN at edge 21
        add(1,  1, 0, 0,  1, 1, 0, 0, 2'd0);
        add(3,  0, 0, 0,  1, 1, 0, 0, 2'd0);
        add(7,  0, 0, 0,  0, 1, 0, 0, 2'd0);
        add(10, 0, 1, 0,  0, 1, 0, 0, 2'd0);
        add(5,  0, 1, 0,  0, 0, 1, 0, 2'd0);
        // drop filter: 1-cycle glitch ignored, 3-cycle drop re-sequences
        add(1,  0, 0, 0,  0, 0, 1, 0, 2'd0);
        add(6,  0, 1, 0,  0, 0, 1, 0, 2'd0);
        add(3,  0, 0, 0,  0, 0, 1, 0, 2'd0);
        add(1,  0, 0, 0,  1, 1, 0, 0, 2'd0);
        add(3,  0, 1, 0,  1, 1, 0, 0, 2'd0);
        add(9,  0, 1, 0,  0, 1, 0, 0, 2'd0);
        add(1,  0, 1, 0,  0, 0, 1, 0, 2'd0);
        // stability restart after a drop in STABLE
        add(1,  1, 1, 0,  1, 1, 0, 0, 2'd0);
        add(3,  0, 1, 0,  1, 1, 0, 0, 2'd0);
        add(6,  0, 1, 0,  0, 1, 0, 0, 2'd0);
        add(1,  0, 0, 0,  0, 1, 0, 0, 2'd0);
        add(10, 0, 1, 0,  0, 1, 0, 0, 2'd0);
        add(1,  0, 1, 0,  0, 0, 1, 0, 2'd0);
        // retries then FAIL, then relock_req recovery
        add(1,  1, 0, 0,  1, 1, 0, 0, 2'd0);
        add(3,  0, 0, 0,  1, 1, 0, 0, 2'd0);
        add(32, 0, 0, 0,  0, 1, 0, 0, 2'd0);
        add(4,  0, 0, 0,  1, 1, 0, 0, 2'd1);
        add(32, 0, 0, 0,  0, 1, 0, 0, 2'd1);
        add(4,  0, 0, 0,  1, 1, 0, 0, 2'd2);
        add(32, 0, 0, 0,  0, 1, 0, 0, 2'd2);
        add(5,  0, 0, 0,  0, 1, 0, 1, 2'd2);
        add(1,  0, 0, 1,  1, 1, 0, 0, 2'd0);
        add(3,  0, 0, 0,  1, 1, 0, 0, 2'd0);
        add(1,  0, 0, 0,  0, 1, 0, 0, 2'd0);
        // relock_req on the STABLE-to-RUN edge wins
        add(1,  1, 1, 0,  1, 1, 0, 0, 2'd0);
        add(3,  0, 1, 0,  1, 1, 0, 0, 2'd0);
        add(9,  0, 1, 0,  0, 1, 0, 0, 2'd0);
        add(1,  0, 1, 1,  1, 1, 0, 0, 2'd0);
        add(3,  0, 1, 0,  1, 1, 0, 0, 2'd0);
        add(1,  0, 1, 0,  0, 1, 0, 0, 2'd0);

        for (int r = 0; r < tbl.size(); r++) begin
            row_idx = r;
            rst = tbl[r].rst;
            pll_locked = tbl[r].lk;
            relock_req = tbl[r].rq;
            for (int k = 0; k < tbl[r].n; k++) begin
                cyc_idx = k;
                @(posedge refclk);
                #1 chk_all(tbl[r].pr, tbl[r].sr, tbl[r].rd, tbl[r].fl, tbl[r].rc);
            end
        end

        // asynchronous reset in the middle of STABLE
        row_idx = 1000;
        cyc_idx = 0;
        relock_req = 1'b0;
        rst = 1'b1;
        @(posedge refclk);
        #1 rst = 1'b0;
        pll_locked = 1'b1;
        repeat (7) @(posedge refclk);
        #1 chk_all(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        #2 rst = 1'b1;
        #1 chk_all(1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        @(posedge refclk);
        #1 rst = 1'b0;
        row_idx = 1001;
        for (int e = 1; e <= 13; e++) begin
            cyc_idx = e;
            @(posedge refclk);
            #1 chk_all(logic'(e < 4), logic'(e != 13), logic'(e == 13), 1'b0, 2'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
